// File: rtl/bram_lsu_port.sv
// bram_lsu_port: load/store requester for one port of a byte-strobe,
// single-clock BRAM with registered read data. It handles one request at a
// time: accept -> drive the BRAM -> capture and align the read data ->
// respond. Every output is driven from a register.
module bram_lsu_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [3:0]            mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

  state_t                state_reg, state_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic [DATA_WIDTH-1:0] resp_rdata_reg, resp_rdata_next;
  logic                  resp_err_reg, resp_err_next;
  logic [ADDR_WIDTH-3:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_din_reg, mem_din_next;
  logic [3:0]            mem_we_reg, mem_we_next;

  // Request attributes captured at accept time, used in the DATA phase.
  logic                  we_reg, we_next;
  logic [1:0]            size_reg, size_next;
  logic                  uns_reg, uns_next;
  logic [1:0]            off_reg, off_next;

  logic                  req_bad;
  logic [3:0]            store_we;
  logic [DATA_WIDTH-1:0] store_din;
  logic [DATA_WIDTH-1:0] rd_shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // Decode legality, byte strobes and lane-replicated data of the request.
  always_comb begin
    req_bad   = (req_size == 2'b11) ||
                ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    store_we  = 4'b0000;
    store_din = '0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          store_we  = 4'b0001 << req_addr[1:0];
          store_din = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          store_we  = req_addr[1] ? 4'b1100 : 4'b0011;
          store_din = {2{req_wdata[15:0]}};
        end
        2'b10: begin
          store_we  = 4'b1111;
          store_din = req_wdata;
        end
        default: begin
          store_we  = 4'b0000;
          store_din = '0;
        end
      endcase
    end
  end

  // Move the addressed lane(s) down to bit 0 and sign/zero-extend.
  always_comb begin
    rd_shifted = mem_dout >> {off_reg, 3'b000};
    case (size_reg)
      2'b00:   load_data = {{24{~uns_reg & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_data = {{16{~uns_reg & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_next      = state_reg;
    req_ready_next  = req_ready_reg;
    resp_valid_next = resp_valid_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    mem_addr_next   = mem_addr_reg;
    mem_din_next    = mem_din_reg;
    mem_we_next     = mem_we_reg;
    we_next         = we_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    off_next        = off_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          req_ready_next = 1'b0;
          we_next        = req_we;
          size_next      = req_size;
          uns_next       = req_unsigned;
          off_next       = req_addr[1:0];
          if (req_bad) begin
            // Errors skip the BRAM entirely and respond on the next cycle.
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = '0;
            mem_we_next     = 4'b0000;
          end else begin
            state_next    = ACCESS;
            mem_addr_next = req_addr[ADDR_WIDTH-1:2];
            mem_we_next   = store_we;
            mem_din_next  = store_din;
          end
        end
      end
      ACCESS: begin
        // BRAM samples on this edge; the strobe lasts exactly one cycle.
        mem_we_next = 4'b0000;
        state_next  = DATA;
      end
      DATA: begin
        resp_rdata_next = we_reg ? '0 : load_data;
        resp_err_next   = 1'b0;
        resp_valid_next = 1'b1;
        state_next      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      mem_addr_reg   <= '0;
      mem_din_reg    <= '0;
      mem_we_reg     <= 4'b0000;
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      off_reg        <= 2'b00;
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      mem_addr_reg   <= mem_addr_next;
      mem_din_reg    <= mem_din_next;
      mem_we_reg     <= mem_we_next;
      we_reg         <= we_next;
      size_reg       <= size_next;
      uns_reg        <= uns_next;
      off_reg        <= off_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_din    = mem_din_reg;
  assign mem_we     = mem_we_reg;

endmodule

// File: tb/tb_bram_lsu_port.sv
// Testbench for bram_lsu_port: a byte-strobe BRAM model with registered
// read, a table of directed load/store vectors, plus hand-written
// back-pressure and mid-access reset sequences.
module tb_bram_lsu_port;

  logic        clk;
  logic        resetb;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  bram_lsu_port #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: byte write strobes, registered (read-first) read data.
  logic [31:0] bram [0:255];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) bram[mem_addr[7:0]][8*i +: 8] <= mem_din[8*i +: 8];
    mem_dout <= bram[mem_addr[7:0]];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_we;
    logic [31:0] exp_din;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, then check the BRAM
  // strobe, latency and the response, completing with resp_ready high.
  task automatic do_req(input vec_t v, input string tag);
    int n;
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    resp_ready   = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk({tag, " req_ready timeout"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;          // accepting edge E0
    req_valid = 1'b0;
    chk({tag, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
    if (v.exp_err) begin
      chk({tag, " err resp_valid@E0"}, 32'(resp_valid), 32'd1);
    end else begin
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.addr >> 2));
      if (v.we) chk({tag, " mem_din"}, mem_din, v.exp_din);
      chk({tag, " resp_valid@E0"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;        // E1: ACCESS edge
      chk({tag, " mem_we@E1"}, 32'(mem_we), 32'd0);
      chk({tag, " resp_valid@E1"}, 32'(resp_valid), 32'd0);
      @(posedge clk); #1;        // E2: data captured
      chk({tag, " resp_valid@E2"}, 32'(resp_valid), 32'd1);
    end
    chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, " err"}, 32'(resp_err), 32'(v.exp_err));
    @(posedge clk); #1;          // response handshake
    chk({tag, " resp_valid after hs"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready after hs"}, 32'(req_ready), 32'd1);
    $display("txn %s: we=%0b size=%0d addr=%h rdata=%h err=%0b",
             tag, v.we, v.size, v.addr, resp_rdata, resp_err);
  endtask

  initial begin
    logic [31:0] held_rdata;
    logic        held_err;
    int          n;

    for (int i = 0; i < 256; i++) bram[i] = 32'h0;
    bram[8] = 32'h11223344;

    //          we    size   uns   addr      wdata         exp_rdata     err   we       din
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 16'h0013, 32'h12345680, 32'h00000000, 1'b0, 4'b1000, 32'h80808080};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 16'h0013, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 16'h0013, 32'h0,        32'h00000080, 1'b0, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'h80ADBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 16'h0012, 32'hABCD1234, 32'h00000000, 1'b0, 4'b1100, 32'h12341234};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'h1234BEEF, 1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 16'h0010, 32'h0,        32'hFFFFBEEF, 1'b0, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 16'h0010, 32'h0,        32'h0000BEEF, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 16'h0011, 32'h0,        32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b1, 16'h0012, 32'h0,        32'h00001234, 1'b0, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 16'h0011, 32'h0,        32'h00000000, 1'b1, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 16'h0013, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b0000, 32'h0};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 16'h0010, 32'h0,        32'h00000000, 1'b1, 4'b0000, 32'h0};
    vecs[15] = '{1'b1, 2'b11, 1'b0, 16'h0010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'b0000, 32'h0};
    vecs[16] = '{1'b0, 2'b10, 1'b0, 16'h0010, 32'h0,        32'h1234BEEF, 1'b0, 4'b0000, 32'h0};

    resetb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 16'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_din", mem_din, 32'd0);
    resetb = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: response held for 5 cycles while a store is offered.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 16'h0010; resp_ready = 1'b0;
    @(posedge clk); #1;                      // accept
    req_we = 1'b1; req_wdata = 32'h55555555; // would corrupt memory if taken
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp resp_valid", 32'(resp_valid), 32'd1);
    held_rdata = resp_rdata;
    held_err   = resp_err;
    chk("bp rdata", resp_rdata, 32'h1234BEEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold valid", 32'(resp_valid), 32'd1);
      chk("bp hold rdata", resp_rdata, held_rdata);
      chk("bp hold err", 32'(resp_err), 32'(held_err));
      chk("bp req_ready", 32'(req_ready), 32'd0);
      chk("bp mem_we", 32'(mem_we), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;                      // handshake
    req_valid = 1'b0;
    chk("bp after hs valid", 32'(resp_valid), 32'd0);
    chk("bp after hs req_ready", 32'(req_ready), 32'd1);
    $display("txn backpressure: rdata=%h", held_rdata);
    do_req(vecs[16], "bp_next");

    // Reset during the ACCESS cycle of a word store to 0x0020.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 16'h0020; req_wdata = 32'hCAFEF00D; resp_ready = 1'b1;
    @(posedge clk); #1;                      // accept, now in ACCESS
    req_valid = 1'b0;
    chk("rst pre mem_we", 32'(mem_we), 32'hF);
    #2 resetb = 1'b0;
    #1;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;
    $display("txn reset-in-access: store dropped");
    do_req('{1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, 32'h11223344, 1'b0, 4'b0000, 32'h0}, "rst_load");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_lsu_port.md
Name: bram_lsu_port

Overview:
- Requester-side master for one port of the team's byte-strobe single-clock BRAM. One clock edge writes or reads the BRAM, and read data appears one cycle later.
- Takes load/store requests on a valid/ready handshake. A request names a byte address, a size and a signedness.
- Turns each request into a BRAM word address, a 4-bit byte write strobe and lane-replicated write data.
- Aligns and sign- or zero-extends read data, then returns it on a valid/ready response channel.
- Sits between the core's load/store stage (or a debug/DMA master) and BRAM port A or B.

Parameters:
- ADDR_WIDTH, 16, byte-address width of req_addr. The BRAM word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32, data width. Fixed at 32, giving 4 byte lanes; other values are unsupported.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- resetb  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready at a rising edge
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_addr  out  ADDR_WIDTH-2  BRAM word address, equal to req_addr[ADDR_WIDTH-1:2]
- mem_din  out  32  BRAM write data
- mem_we  out  4  BRAM byte write strobes; bit i enables byte i
- mem_dout  in  32  BRAM registered read data

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_err = 0
  - mem_we = 0, mem_addr = 0, mem_din = 0
- Reset mid-operation: any in-flight request or pending response is dropped. Because mem_we clears asynchronously, a store whose ACCESS edge has not yet occurred does not reach the BRAM.
- All outputs are registered. req_ready is asserted only in IDLE, and only one request is ever outstanding.
- FSM states: IDLE, ACCESS, DATA, RESP.
- IDLE, on the accepting edge:
  - Latch we, size, unsigned and addr[1:0].
  - Legality: an access is misaligned if size = 01 and addr[0] = 1, or size = 10 and addr[1:0] != 00. size = 11 is illegal.
  - Illegal or misaligned: go to RESP with resp_err = 1 and resp_rdata = 0. mem_we stays 0.
  - Otherwise: load mem_addr, mem_din and mem_we, then go to ACCESS.
- Store strobes and data:
  - Byte: mem_we = 4'b0001 << addr[1:0]; mem_din = {4{wdata[7:0]}}.
  - Halfword: mem_we = addr[1] ? 4'b1100 : 4'b0011; mem_din = {2{wdata[15:0]}}.
  - Word: mem_we = 4'b1111; mem_din = wdata.
  - Loads: mem_we = 0; mem_din is don't-care, held at 0.
- ACCESS: the BRAM samples on this cycle's edge. Then mem_we = 0 (single-cycle strobe) and state goes to DATA. mem_addr is held.
- DATA: mem_dout is valid.
  - Loads: shift mem_dout right by 8*addr[1:0], take 8 or 16 or 32 bits, then extend per unsigned.
  - Stores: resp_rdata = 0. Write-first readback is ignored.
  - Register the result, set resp_err = 0, go to RESP.
- RESP: resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready. On the handshake edge: resp_valid = 0, go to IDLE, req_ready = 1.
- Latency: a legal request accepted at edge E0 gives resp_valid high after E2. An error request gives resp_valid high after E0.
- Throughput: at best one request per 4 cycles with resp_ready held high.
- Simultaneous events: req_valid while not in IDLE is ignored (req_ready = 0). A response handshake and a new request cannot share an edge.
- Address arithmetic is never carried beyond ADDR_WIDTH. The top address wraps naturally; no range check.

Test Plan:
1. Word store 0xDEADBEEF @0x0010, then word load @0x0010 -> mem_we = 1111 for exactly one cycle, mem_addr = 4. Load resp_rdata = 0xDEADBEEF with resp_valid rising 3 edges after accept; resp_err = 0.
2. Byte store 0x80 @0x0013 -> mem_we = 1000, mem_din = 0x80808080. Then:
   - signed byte load @0x0013 -> 0xFFFFFF80
   - unsigned byte load @0x0013 -> 0x00000080
   - word load @0x0010 -> 0x80ADBEEF
3. Half store 0x1234 @0x0012 -> mem_we = 1100, mem_din = 0x12341234. Then:
   - word load @0x0010 -> 0x1234BEEF
   - signed half load @0x0010 -> 0xFFFFBEEF
   - unsigned half load @0x0010 -> 0x0000BEEF
4. Word load @0x0011, half store @0x0013, and any size = 11 -> mem_we stays 0000, resp_err = 1, resp_rdata = 0, resp_valid one edge after accept. Memory is unchanged.
5. Load with resp_ready held low 5 cycles while req_valid = 1 -> resp_valid, resp_rdata and resp_err stable and req_ready = 0 throughout. After the handshake, req_ready = 1 and the next request is accepted.
6. Assert resetb low during ACCESS of a word store 0xCAFEF00D @0x0020 -> mem_we = 0 and resp_valid = 0 immediately. After release req_ready = 1, and a word load @0x0020 returns the prior contents.
